// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared instruction/data memory port: fetch vs load/store.
// Round-robin on ties, whole-burst grants, response steering and a no-ack watchdog.
module mem_port_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int TMO_CYCLES = 255,
  parameter int TMO_WIDTH  = 8
) (
  input  logic              a_clk,
  input  logic              a_rst,
  // fetch requester
  input  logic              a_i_syn_f,
  input  logic [AWIDTH-1:0] a_i_addr_f,
  output logic              a_o_ack_f,
  output logic              a_o_last_f,
  output logic [DWIDTH-1:0] a_o_data_f,
  // load/store requester
  input  logic              a_i_syn_d,
  input  logic              a_i_we_d,
  input  logic [AWIDTH-1:0] a_i_addr_d,
  input  logic [DWIDTH-1:0] a_i_wdata_d,
  output logic              a_o_ack_d,
  output logic              a_o_last_d,
  output logic [DWIDTH-1:0] a_o_data_d,
  // memory port
  output logic              a_o_syn,
  output logic              a_o_we,
  output logic [AWIDTH-1:0] a_o_addr,
  output logic [DWIDTH-1:0] a_o_wdata,
  input  logic              a_i_ack,
  input  logic              a_i_last,
  input  logic [DWIDTH-1:0] a_i_rdata,
  // status
  output logic              a_o_busy,
  output logic              a_o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_F = 2'd1,
    GNT_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TMO_CYCLES - 1);

  state_e               state_q, state_d;
  owner_e               last_grant_q, last_grant_d;
  logic [TMO_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;

  logic gnt_syn;
  logic burst_end;
  logic wd_expire;

  assign gnt_syn   = (state_q == GNT_F) ? a_i_syn_f : a_i_syn_d;
  assign burst_end = a_i_ack & a_i_last;
  assign wd_expire = !a_i_ack && (tmo_cnt_q == TMO_LIMIT);

  // Next-state: a completed burst beats the watchdog, which beats a requester abort.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_i_syn_f && (!a_i_syn_d || last_grant_q == OWN_D)) begin
          state_d      = GNT_F;
          last_grant_d = OWN_F;
          tmo_cnt_d    = '0;
        end else if (a_i_syn_d) begin
          state_d      = GNT_D;
          last_grant_d = OWN_D;
          tmo_cnt_d    = '0;
        end
      end
      GNT_F, GNT_D: begin
        if (burst_end) begin
          state_d   = IDLE;
          tmo_cnt_d = '0;
        end else if (wd_expire) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          tmo_cnt_d = '0;
        end else if (!gnt_syn) begin
          state_d   = IDLE;
          tmo_cnt_d = '0;
        end else if (a_i_ack) begin
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q != '1) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        tmo_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_D;
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  // Request and response steering follow the registered grant, so reset clears them at once.
  always_comb begin
    a_o_syn    = 1'b0;
    a_o_we     = 1'b0;
    a_o_addr   = '0;
    a_o_wdata  = '0;
    a_o_ack_f  = 1'b0;
    a_o_last_f = 1'b0;
    a_o_data_f = '0;
    a_o_ack_d  = 1'b0;
    a_o_last_d = 1'b0;
    a_o_data_d = '0;

    case (state_q)
      GNT_F: begin
        a_o_syn    = 1'b1;
        a_o_addr   = a_i_addr_f;
        a_o_ack_f  = a_i_ack;
        a_o_last_f = burst_end;
        a_o_data_f = a_i_rdata;
      end
      GNT_D: begin
        a_o_syn    = 1'b1;
        a_o_we     = a_i_we_d;
        a_o_addr   = a_i_addr_d;
        a_o_wdata  = a_i_wdata_d;
        a_o_ack_d  = a_i_ack;
        a_o_last_d = burst_end;
        a_o_data_d = a_i_rdata;
      end
      default: ;
    endcase
  end

  assign a_o_busy    = busy_q;
  assign a_o_timeout = timeout_q;

  a_one_ack: assert property (@(posedge a_clk) disable iff (a_rst) !(a_o_ack_f && a_o_ack_d));
  a_syn_busy: assert property (@(posedge a_clk) disable iff (a_rst) a_o_syn == a_o_busy);
  a_tmo_idle: assert property (@(posedge a_clk) disable iff (a_rst) a_o_timeout |-> !a_o_busy);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic scored
// against a cycle-level ownership model of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          a_clk = 1'b0;
  logic          a_rst;
  logic          a_i_syn_f, a_i_syn_d, a_i_we_d, a_i_ack, a_i_last;
  logic [AW-1:0] a_i_addr_f, a_i_addr_d;
  logic [DW-1:0] a_i_wdata_d, a_i_rdata;
  logic          a_o_ack_f, a_o_last_f, a_o_ack_d, a_o_last_d;
  logic [DW-1:0] a_o_data_f, a_o_data_d, a_o_wdata;
  logic          a_o_syn, a_o_we, a_o_busy, a_o_timeout;
  logic [AW-1:0] a_o_addr;

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TMO_CYCLES(TMO), .TMO_WIDTH(8)) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .a_i_syn_f(a_i_syn_f), .a_i_addr_f(a_i_addr_f),
    .a_o_ack_f(a_o_ack_f), .a_o_last_f(a_o_last_f), .a_o_data_f(a_o_data_f),
    .a_i_syn_d(a_i_syn_d), .a_i_we_d(a_i_we_d), .a_i_addr_d(a_i_addr_d),
    .a_i_wdata_d(a_i_wdata_d),
    .a_o_ack_d(a_o_ack_d), .a_o_last_d(a_o_last_d), .a_o_data_d(a_o_data_d),
    .a_o_syn(a_o_syn), .a_o_we(a_o_we), .a_o_addr(a_o_addr), .a_o_wdata(a_o_wdata),
    .a_i_ack(a_i_ack), .a_i_last(a_i_last), .a_i_rdata(a_i_rdata),
    .a_o_busy(a_o_busy), .a_o_timeout(a_o_timeout)
  );

  always #5 a_clk = ~a_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 fetch, 2 load/store), who was
  // granted last, how long the current owner has waited without an ack.
  int m_owner, m_last, m_wait;
  bit m_tmo;

  function automatic void model_reset();
    m_owner = 0; m_last = 2; m_wait = 0; m_tmo = 0;
  endfunction

  function automatic void model_tick();
    bit still_wants;
    m_tmo = 0;
    if (m_owner == 0) begin
      if (a_i_syn_f && a_i_syn_d) m_owner = (m_last == 1) ? 2 : 1;
      else if (a_i_syn_f)         m_owner = 1;
      else if (a_i_syn_d)         m_owner = 2;
      if (m_owner != 0) begin m_last = m_owner; m_wait = 0; end
    end else begin
      still_wants = (m_owner == 1) ? a_i_syn_f : a_i_syn_d;
      if (a_i_ack && a_i_last)              begin m_owner = 0; m_wait = 0; end
      else if (!a_i_ack && m_wait == TMO-1) begin m_owner = 0; m_wait = 0; m_tmo = 1; end
      else if (!still_wants)                begin m_owner = 0; m_wait = 0; end
      else if (a_i_ack)                     m_wait = 0;
      else                                  m_wait++;
    end
  endfunction

  task automatic compare_model();
    bit f, d;
    f = (m_owner == 1);
    d = (m_owner == 2);
    check("syn",     a_o_syn,     m_owner != 0);
    check("busy",    a_o_busy,    m_owner != 0);
    check("timeout", a_o_timeout, m_tmo);
    check("we",      a_o_we,      d && a_i_we_d);
    check("addr",    a_o_addr,    f ? a_i_addr_f : (d ? a_i_addr_d : '0));
    check("wdata",   a_o_wdata,   d ? a_i_wdata_d : '0);
    check("ack_f",   a_o_ack_f,   f && a_i_ack);
    check("last_f",  a_o_last_f,  f && a_i_ack && a_i_last);
    check("data_f",  a_o_data_f,  f ? a_i_rdata : '0);
    check("ack_d",   a_o_ack_d,   d && a_i_ack);
    check("last_d",  a_o_last_d,  d && a_i_ack && a_i_last);
    check("data_d",  a_o_data_d,  d ? a_i_rdata : '0);
  endtask

  // One clock: score outputs mid-cycle, advance the model on the edge, return just after it.
  task automatic step();
    @(negedge a_clk);
    compare_model();
    @(posedge a_clk);
    if (a_rst) model_reset();
    else       model_tick();
    #1;
  endtask

  task automatic clear_inputs();
    a_i_syn_f = 0; a_i_addr_f = '0;
    a_i_syn_d = 0; a_i_we_d = 0; a_i_addr_d = '0; a_i_wdata_d = '0;
    a_i_ack = 0; a_i_last = 0; a_i_rdata = '0;
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    model_reset();
    step();
    a_rst = 1'b0;
  endtask

  logic [DW-1:0] beat_data [4];

  initial begin
    beat_data[0] = 32'h13; beat_data[1] = 32'h93;
    beat_data[2] = 32'h113; beat_data[3] = 32'h193;
    clear_inputs();
    do_reset();
    check("rst_busy", a_o_busy, 0);
    check("rst_syn", a_o_syn, 0);

    // Fetch-only 4-beat burst
    a_i_syn_f = 1; a_i_addr_f = 32'h0;
    step();
    check("f_syn", a_o_syn, 1);
    check("f_addr", a_o_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      a_i_ack = 1; a_i_last = (i == 3); a_i_rdata = beat_data[i];
      #1;
      check("f_ack", a_o_ack_f, 1);
      check("f_last", a_o_last_f, i == 3);
      check("f_data", a_o_data_f, beat_data[i]);
      check("f_ack_d", a_o_ack_d, 0);
      step();
    end
    clear_inputs();
    #1;
    check("f_end_syn", a_o_syn, 0);
    check("f_end_busy", a_o_busy, 0);

    // Simultaneous requests after reset: fetch, then store, then fetch again
    do_reset();
    a_i_syn_f = 1; a_i_addr_f = 32'h100;
    a_i_syn_d = 1; a_i_we_d = 1; a_i_addr_d = 32'h2000; a_i_wdata_d = 32'hDEADBEEF;
    step();
    check("tie1_addr", a_o_addr, 32'h100);
    check("tie1_we", a_o_we, 0);
    a_i_ack = 1; a_i_last = 0; step();
    a_i_last = 1; step();
    a_i_syn_f = 0; a_i_ack = 0; a_i_last = 0;
    #1;
    check("gap_busy", a_o_busy, 0);
    step();
    check("st_we", a_o_we, 1);
    check("st_addr", a_o_addr, 32'h2000);
    check("st_wdata", a_o_wdata, 32'hDEADBEEF);
    a_i_ack = 1; a_i_last = 1; step();
    a_i_ack = 0; a_i_last = 0; a_i_syn_f = 1;
    step();
    check("tie3_fetch", a_o_addr, 32'h100);
    check("tie3_we", a_o_we, 0);
    a_i_ack = 1; a_i_last = 1; step();
    clear_inputs();
    step();

    // Stray ack while idle
    a_i_ack = 1; a_i_last = 1; a_i_rdata = 32'h5A5A;
    #1;
    check("stray_ack_f", a_o_ack_f, 0);
    check("stray_last_d", a_o_last_d, 0);
    step();
    check("stray_busy", a_o_busy, 0);
    clear_inputs();

    // Watchdog: load granted, memory silent, fetch waiting
    a_i_syn_d = 1; a_i_addr_d = 32'h40;
    step();
    a_i_syn_f = 1; a_i_addr_f = 32'h800;
    for (int i = 0; i < TMO; i++) begin
      check("wd_busy", a_o_busy, 1);
      step();
    end
    check("wd_tmo", a_o_timeout, 1);
    check("wd_syn", a_o_syn, 0);
    step();
    check("wd_tmo_once", a_o_timeout, 0);
    check("wd_next_f", a_o_addr, 32'h800);
    a_i_ack = 1; a_i_last = 1; step();
    clear_inputs();
    step();

    // Abort: fetch drops syn after two beats
    a_i_syn_f = 1; a_i_addr_f = 32'h300;
    step();
    a_i_ack = 1; a_i_last = 0; step(); step();
    a_i_syn_f = 0; a_i_ack = 0;
    step();
    check("ab_syn", a_o_syn, 0);
    check("ab_busy", a_o_busy, 0);
    a_i_ack = 1;
    #1;
    check("ab_no_ack", a_o_ack_f, 0);
    step();
    clear_inputs();

    // Reset between edges during a load/store grant
    a_i_syn_d = 1; a_i_addr_d = 32'h900;
    step();
    a_i_ack = 1;
    #1;
    check("mr_pre_ack", a_o_ack_d, 1);
    a_rst = 1;
    #1;
    check("mr_syn", a_o_syn, 0);
    check("mr_ack_d", a_o_ack_d, 0);
    check("mr_busy", a_o_busy, 0);
    model_reset();
    step();
    a_rst = 0;
    a_i_ack = 0;
    a_i_syn_f = 1; a_i_addr_f = 32'hA00;
    step();
    check("mr_tie_f", a_o_addr, 32'hA00);
    a_i_ack = 1; a_i_last = 1; step();
    clear_inputs();
    step();

    // Randomized traffic, alternating responsive and stalling memory
    for (int i = 0; i < 3000; i++) begin
      bit stall;
      stall = ((i / 250) % 2) == 1;
      a_i_syn_f   = a_i_syn_f ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
      a_i_syn_d   = a_i_syn_d ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
      a_i_addr_f  = $urandom;
      a_i_addr_d  = $urandom;
      a_i_we_d    = $urandom_range(0, 1) == 1;
      a_i_wdata_d = $urandom;
      a_i_rdata   = $urandom;
      a_i_ack     = stall ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 70);
      a_i_last    = $urandom_range(0, 99) < 35;
      if ($urandom_range(0, 299) == 0) begin
        a_rst = 1;
        model_reset();
      end else begin
        a_rst = 0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
